prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer-side counterpart to the instruction fetch path. Accepts a stream of 32-bit
//  program words over a valid/ready handshake and writes them into the behavioural
//  mem unit at consecutive word-aligned addresses starting at BASE. It then re-reads
//  the image and compares checksums. Finally it reports done/err and the entry PC
//  for the fetch stage. Sits between the testbench/host stream and mem's ports.
// PARAMETERS
//  BASE       32'h28  first write address and reported entry PC; must be word-aligned
//  MAX_WORDS  1024    maximum image length in words; count width = $clog2(MAX_WORDS)+1
// PORTS
//  clk        in   1   single clock, all state changes on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   pulse: begin a load; honoured only in IDLE or DONE
//  in_valid   in   1   stream word valid
//  in_data    in   32  stream word
//  in_last    in   1   marks final word of image (qualified by in_valid&in_ready)
//  in_ready   out  1   loader can accept a word this cycle
//  mem_addr   out  32  to mem address (registered)
//  mem_din    out  32  to mem memIn (registered)
//  mem_we     out  1   to mem write (registered, one-cycle pulse per word)
//  mem_re     out  1   to mem read (registered)
//  mem_dout   in   32  from mem memOut (combinational function of mem_addr)
//  busy       out  1   state not IDLE/DONE
//  done       out  1   load and verify complete; held until next start
//  err        out  1   valid with done: checksum mismatch or MAX_WORDS overflow
//  entry_pc   out  32  constant BASE; fetch PC initial value
//  word_count out  CW  words written in last/current load
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_addr/mem_din/word_count=0; mem_we/mem_re/in_ready/
//   busy/done/err=0; entry_pc=BASE. Reset mid-load drops mem_we immediately;
//   memory words already written stay written.
//  States: IDLE -> LOAD -> FLUSH -> VERIFY -> DONE -> (start) LOAD.
//  IDLE: in_ready=0; in_valid ignored. start -> LOAD; wptr=BASE, count=0, wsum=0.
//  LOAD: in_ready=1 (combinational, state==LOAD). On each accept at edge k:
//   mem_addr<=wptr, mem_din<=in_data, mem_we<=1. The word lands in mem at edge k+1.
//   Also wptr+=4, count+=1, wsum+=in_data (mod 2^32). A cycle without an accept gives
//   mem_we<=0. Exit to FLUSH when an accept has in_last=1, or when count+1==MAX_WORDS.
//   Reaching MAX_WORDS without in_last sets ovf (sticky until start). in_last on
//   exactly the MAX_WORDS-th word is a normal end, ovf=0.
//  FLUSH: one cycle, in_ready=0, mem_we<=0 (last write completes); rptr=BASE,
//   vcount=0, vsum=0; mem_addr<=BASE, mem_re<=1.
//  VERIFY: mem_re=1. Each edge: vsum+=mem_dout, vcount+=1, rptr+=4, mem_addr<=rptr+4.
//   When vcount+1==count -> DONE with mem_re<=0. If count==0, skip VERIFY -> DONE.
//  DONE: done=1, err=(vsum!=wsum)|ovf, busy=0, word_count held. start -> LOAD clears
//   done/err the same edge. start is ignored in LOAD/FLUSH/VERIFY.
//  Addresses wrap mod 2^32; all arithmetic unsigned 32-bit, carries dropped.
//  mem_we and mem_re are never asserted in the same cycle.
//  Total latency: N accepted words, then 1 FLUSH cycle, then N VERIFY cycles, then done.
// STRUCTURE
//  Shared package ldr_pkg: state encoding localparams (IDLE,LOAD,FLUSH,VERIFY,DONE),
//   WORD_BYTES=4.
//  One sub-module: ldr_csum (32-bit accumulator with clr/en, async rst_n),
//   instantiated twice (wsum, vsum). FSM and pointers live in prog_loader.
// TESTING (bench instantiates prog_loader + mem, CAPACITY default)
//  1 reset then start; stream 3 words 0x11,0x22,0x33 (last on 3rd) -> mem[0x28]=0x11,
//    [0x2C]=0x22, [0x30]=0x33; done=1, err=0, word_count=3, entry_pc=0x28.
//  2 in_valid toggled every other cycle, 4 words -> mem_we pulses exactly 4 times;
//    addresses 0x28,0x2C,0x30,0x34 in order; no write in idle gaps.
//  3 MAX_WORDS=4, stream 6 words, no in_last -> 4 words written, in_ready=0 after
//    the 4th; done=1, err=1; mem[0x38] unchanged.
//  4 force mem_dout bit flip during VERIFY of word 2 -> done=1, err=1;
//    rerun start -> err=0.
//  5 assert rst_n=0 after 2nd accept in LOAD -> mem_we=0 at once, state IDLE,
//    done=0; start again reloads from 0x28.
//  6 start pulsed during VERIFY -> ignored; single done, word_count unchanged.

Source files
------------

// File: rtl/ldr_pkg.sv
// Shared definitions for the program loader: FSM states and address stride.
package ldr_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VERIFY,
    DONE
  } state_t;

endpackage

// File: rtl/ldr_csum.sv
// 32-bit modular checksum accumulator; clr has priority over en.
module ldr_csum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams program words into memory from BASE upward, re-reads them to compare
// checksums, then reports done/err and the fetch entry PC.
module prog_loader
  import ldr_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h28,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [31:0]                  in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_din,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [31:0]                  mem_dout,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [31:0]                  entry_pc,
  output logic [$clog2(MAX_WORDS):0]   word_count
);

  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;

  state_t          state, state_nx;
  logic [31:0]     wptr, rptr;
  logic [CW-1:0]   count, vcount;
  logic [CW-1:0]   count_inc, vcount_inc;
  logic            ovf;
  logic            accept, start_ok, cap_hit, verify_last;
  logic [31:0]     wsum, vsum;

  assign accept      = in_valid && (state == LOAD);
  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign count_inc   = count + CW'(1);
  assign vcount_inc  = vcount + CW'(1);
  assign cap_hit     = (count_inc == CW'(MAX_WORDS));
  assign verify_last = (vcount_inc == count);

  assign entry_pc   = BASE;
  assign word_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (in_last || cap_hit)) state_nx = FLUSH;
      end
      FLUSH: begin
        busy     = 1'b1;
        state_nx = (count == '0) ? DONE : VERIFY;
      end
      VERIFY: begin
        busy = 1'b1;
        if (verify_last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        err  = (vsum != wsum) || ovf;
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // mem_we is a one-cycle pulse: cleared every edge unless a word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= BASE;
      rptr     <= BASE;
      count    <= '0;
      vcount   <= '0;
      ovf      <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wptr  <= BASE;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_addr <= wptr;
            mem_din  <= in_data;
            mem_we   <= 1'b1;
            wptr     <= wptr + WORD_BYTES;
            count    <= count_inc;
            if (cap_hit && !in_last) ovf <= 1'b1;
          end
        end
        FLUSH: begin
          rptr     <= BASE;
          vcount   <= '0;
          mem_addr <= BASE;
          mem_re   <= (count != '0);
        end
        VERIFY: begin
          vcount   <= vcount_inc;
          rptr     <= rptr + WORD_BYTES;
          mem_addr <= rptr + WORD_BYTES;
          if (verify_last) mem_re <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  ldr_csum u_wsum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (accept),
    .din   (in_data),
    .sum   (wsum)
  );

  ldr_csum u_vsum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == FLUSH),
    .en    (state == VERIFY),
    .din   (mem_dout),
    .sum   (vsum)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with a behavioural word memory and a phase-level model.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h28;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we, mem_re, busy, done, err;
  logic [31:0] entry_pc;
  logic [2:0]  word_count;
  logic [31:0] flip = '0;

  int n_chk = 0;
  int n_pass = 0;

  prog_loader #(.BASE(BASE), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_dout   (mem_dout),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .entry_pc   (entry_pc),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Behavioural memory: 256 words, combinational read, write on posedge.
  logic [31:0] memarr [256];
  assign mem_dout = memarr[mem_addr[9:2]] ^ flip;

  initial begin
    for (int i = 0; i < 256; i++) memarr[i] = 32'hA5A5_0000 | i;
    forever begin
      @(posedge clk);
      if (mem_we) memarr[mem_addr[9:2]] <= mem_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: loading phase, countdown of cycles left before done, expected write.
  bit          m_loading = 0, m_done = 0, m_ovf = 0, m_corrupt = 0;
  int          m_tail = 0, m_cnt = 0;
  bit          exp_we = 0;
  logic [31:0] exp_addr = '0, exp_din = '0;
  logic [31:0] m_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'hA5A5_0000 | i;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_loading = 0; m_done = 0; m_ovf = 0; m_tail = 0; m_cnt = 0;
        exp_we = 0; exp_addr = '0; exp_din = '0;
      end else begin
        if (exp_we) m_mem[exp_addr[9:2]] = exp_din;
        exp_we = 0;
        if (!m_loading && m_tail == 0) begin
          if (start) begin
            m_loading = 1; m_cnt = 0; m_done = 0; m_ovf = 0;
          end
        end else if (m_loading) begin
          if (in_valid) begin
            exp_we   = 1;
            exp_addr = BASE + 32'(4 * m_cnt);
            exp_din  = in_data;
            m_cnt++;
            if (in_last || m_cnt == MAXW) begin
              m_loading = 0;
              m_ovf     = !in_last;
              m_tail    = m_cnt + 1;   // one flush cycle plus one read per word
            end
          end
        end else begin
          m_tail--;
          if (m_tail == 0) m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_re;
    exp_re = (m_tail >= 1) && (m_tail <= m_cnt);
    chk("in_ready", in_ready, m_loading);
    chk("mem_we", mem_we, exp_we);
    if (exp_we) begin
      chk("wr_addr", mem_addr, exp_addr);
      chk("wr_data", mem_din, exp_din);
    end
    chk("mem_re", mem_re, exp_re);
    if (exp_re) chk("rd_addr", mem_addr, BASE + 32'(4 * (m_cnt - m_tail)));
    chk("done", done, m_done);
    chk("busy", busy, m_loading || (m_tail > 0));
    chk("err", err, m_done && (m_ovf || m_corrupt));
    chk("word_count", word_count, 32'(m_cnt));
    chk("entry_pc", entry_pc, BASE);
    chk("we_re_excl", mem_we & mem_re, 1'b0);
  end

  int          we_cnt = 0, done_rises = 0;
  logic [31:0] we_addrs[$];
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      we_cnt++;
      we_addrs.push_back(mem_addr);
    end
    if (done && !done_prev) done_rises++;
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_corrupt = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, output bit ok);
    in_valid = 1'b1; in_data = d; in_last = last; ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; in_data = 32'hBAD0_BAD0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    tick();
  endtask

  task automatic wait_re_at(input logic [31:0] addr, output bit seen);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_re && mem_addr == addr) seen = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit oks[6];
    bit seen;
    logic [31:0] t2_addr [4];
    int mism;
    t2_addr = '{32'h28, 32'h2C, 32'h30, 32'h34};

    // Test 1: reset, then a 3-word image.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wc", word_count, 3'd0);
    chk("rst_pc", entry_pc, 32'h28);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    pulse_start();
    send(32'h11, 1'b0, ok); chk("t1_acc0", ok, 1'b1);
    send(32'h22, 1'b0, ok); chk("t1_acc1", ok, 1'b1);
    send(32'h33, 1'b1, ok); chk("t1_acc2", ok, 1'b1);
    idle_in();
    wait_done("t1");
    chk("t1_mem28", memarr[32'h28 >> 2], 32'h11);
    chk("t1_mem2c", memarr[32'h2C >> 2], 32'h22);
    chk("t1_mem30", memarr[32'h30 >> 2], 32'h33);
    chk("t1_done", done, 1'b1);
    chk("t1_err", err, 1'b0);
    chk("t1_wc", word_count, 3'd3);
    chk("t1_pc", entry_pc, 32'h28);

    // Test 2: valid toggled every other cycle; last lands on the MAX_WORDS-th word.
    we_cnt = 0;
    we_addrs.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      idle_in();
      tick();
      send(32'h200 + 32'(i), (i == 3), ok);
      chk("t2_acc", ok, 1'b1);
    end
    idle_in();
    wait_done("t2");
    chk("t2_we_cnt", we_cnt, 4);
    for (int i = 0; i < 4; i++)
      chk("t2_we_addr", (i < we_addrs.size()) ? we_addrs[i] : 32'hFFFF_FFFF, t2_addr[i]);
    chk("t2_err", err, 1'b0);
    chk("t2_wc", word_count, 3'd4);

    // Test 3: 6 words with no last; capacity of 4 stops the load.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(32'h300 + 32'(i), 1'b0, oks[i]);
      if (i == 3) chk("t3_ready_after4", in_ready, 1'b0);
    end
    idle_in();
    for (int i = 0; i < 6; i++) chk("t3_acc", oks[i], (i < 4));
    wait_done("t3");
    chk("t3_done", done, 1'b1);
    chk("t3_err", err, 1'b1);
    chk("t3_wc", word_count, 3'd4);
    chk("t3_mem34", memarr[32'h34 >> 2], 32'h303);
    chk("t3_mem38", memarr[32'h38 >> 2], 32'hA5A5_000E);

    // Test 4: corrupt the second read-back word, then reload cleanly.
    pulse_start();
    send(32'h1000, 1'b0, ok); chk("t4_acc", ok, 1'b1);
    send(32'h2000, 1'b0, ok); chk("t4_acc", ok, 1'b1);
    send(32'h3000, 1'b1, ok); chk("t4_acc", ok, 1'b1);
    idle_in();
    wait_re_at(BASE + 32'h4, seen);
    chk("t4_rd_word2_seen", seen, 1'b1);
    flip = 32'h0000_0100;
    @(posedge clk);
    #1 flip = '0;
    m_corrupt = 1;
    wait_done("t4a");
    chk("t4_err_bad", err, 1'b1);
    pulse_start();
    send(32'h1000, 1'b0, ok); chk("t4_acc", ok, 1'b1);
    send(32'h2000, 1'b0, ok); chk("t4_acc", ok, 1'b1);
    send(32'h3000, 1'b1, ok); chk("t4_acc", ok, 1'b1);
    idle_in();
    wait_done("t4b");
    chk("t4_err_good", err, 1'b0);

    // Test 5: reset right after the second accept; the in-flight write is dropped.
    pulse_start();
    send(32'h501, 1'b0, ok); chk("t5_acc", ok, 1'b1);
    send(32'h502, 1'b0, ok); chk("t5_acc", ok, 1'b1);
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("t5_we_drop", mem_we, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_mem28_kept", memarr[32'h28 >> 2], 32'h501);
    chk("t5_mem2c_old", memarr[32'h2C >> 2], 32'h2000);
    tick();
    pulse_start();
    send(32'h77, 1'b0, ok); chk("t5_acc", ok, 1'b1);
    send(32'h88, 1'b1, ok); chk("t5_acc", ok, 1'b1);
    idle_in();
    wait_done("t5");
    chk("t5_mem28", memarr[32'h28 >> 2], 32'h77);
    chk("t5_mem2c", memarr[32'h2C >> 2], 32'h88);
    chk("t5_wc", word_count, 3'd2);
    chk("t5_err", err, 1'b0);

    // Test 6: start during read-back is ignored.
    done_rises = 0;
    pulse_start();
    send(32'h601, 1'b0, ok); chk("t6_acc", ok, 1'b1);
    send(32'h602, 1'b0, ok); chk("t6_acc", ok, 1'b1);
    send(32'h603, 1'b1, ok); chk("t6_acc", ok, 1'b1);
    idle_in();
    wait_re_at(BASE, seen);
    chk("t6_verify_seen", seen, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t6");
    repeat (3) tick();
    chk("t6_done_rises", done_rises, 1);
    chk("t6_done_held", done, 1'b1);
    chk("t6_wc", word_count, 3'd3);
    chk("t6_err", err, 1'b0);

    mism = 0;
    for (int i = 0; i < 256; i++) if (memarr[i] !== m_mem[i]) mism++;
    chk("mem_image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
